// File: rtl/vga_controller_pkg.sv
// vga_controller_pkg
// Shared constants, ball axis state type and the per-axis bounce helper used by
// vga_controller. No ports. Imported by vga_controller and lfsr18.
package vga_controller_pkg;

  localparam logic [9:0]  H_VISIBLE   = 10'd640;
  localparam logic [9:0]  V_VISIBLE   = 10'd480;
  localparam logic [9:0]  H_MAX       = 10'd800;
  localparam logic [9:0]  V_MAX       = 10'd525;
  localparam logic [9:0]  BALL_SIZE   = 10'd16;
  localparam logic [9:0]  X_LIMIT     = 10'd624;
  localparam logic [9:0]  Y_LIMIT     = 10'd464;
  localparam logic [11:0] BALL_COLOR  = 12'hFFF;
  localparam logic [11:0] BG_COLOR    = 12'h008;
  localparam logic [11:0] BLANK_COLOR = 12'h000;
  localparam logic [17:0] LFSR_SEED   = 18'h00001;

  // Ball state after reset: roughly centred, moving right/down.
  localparam logic [9:0]  RST_XPOS    = 10'd312;
  localparam logic [9:0]  RST_YPOS    = 10'd232;
  localparam logic [5:0]  RST_XSPEED  = 6'd2;
  localparam logic [5:0]  RST_YSPEED  = 6'd1;

  // One axis of ball motion: unsigned position, two's-complement speed.
  typedef struct packed {
    logic [9:0] pos;
    logic [5:0] speed;
  } axis_state_t;

  // Magnitude of a two's-complement speed.
  function automatic logic [5:0] speed_mag(input logic [5:0] speed);
    if (speed[5]) begin
      return 6'd0 - speed;
    end else begin
      return speed;
    end
  endfunction

  // Advance one axis by one frame, reflecting off 0 and off limit.
  // bounce_mag is the speed magnitude applied when a wall is hit.
  function automatic axis_state_t axis_bounce(input axis_state_t cur,
                                              input logic [9:0]  limit,
                                              input logic [5:0]  bounce_mag);
    logic signed [11:0] nx;
    axis_state_t        nxt;
    nx = $signed({2'b00, cur.pos}) + $signed({{6{cur.speed[5]}}, cur.speed});
    if (nx <= 12'sd0) begin
      nxt.pos   = 10'd0;
      nxt.speed = bounce_mag;
    end else if (nx >= $signed({2'b00, limit})) begin
      nxt.pos   = limit;
      nxt.speed = 6'd0 - bounce_mag;
    end else begin
      nxt.pos   = nx[9:0];
      nxt.speed = cur.speed;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/vga_controller_lfsr18.sv
// lfsr18
// 18-bit shift-left LFSR, feedback q[17]^q[10]. Recovers from the all-zero
// lock-up state by reloading the seed.
// Ports:
//   CLK    - clock, rising edge
//   ARST_L - asynchronous reset, active-high (loads LFSR_SEED)
//   q      - current LFSR state
module lfsr18
  import vga_controller_pkg::*;
(
  input  logic        CLK,
  input  logic        ARST_L,
  output logic [17:0] q
);

  logic [17:0] q_r;

  // LFSR state register with zero-state recovery.
  always_ff @(posedge CLK or posedge ARST_L) begin
    if (ARST_L) begin
      q_r <= LFSR_SEED;
    end else if (q_r == 18'd0) begin
      q_r <= LFSR_SEED;
    end else begin
      q_r <= {q_r[16:0], q_r[17] ^ q_r[10]};
    end
  end

  assign q = q_r;

endmodule

// File: rtl/vga_controller.sv
// vga_controller
// Bouncing-ball pixel generator: moves a 16x16 ball once per frame, bouncing
// off the screen edges, and colours each pixel from the current scan position.
// Optional macro VGA_CTRL_RANDOM_SPEED_EN: when defined, each bounce picks a
// new speed magnitude from the LFSR (X: SREG[2:0]+1, Y: SREG[5:3]+1).
// Ports:
//   CLK            - clock, rising edge
//   ARST_L         - asynchronous reset, active-high
//   HCOORD/VCOORD  - scan position (0..800 / 0..525)
//   rollover_i     - end-of-frame tick (combinational)
//   SREG           - LFSR state
//   CSEL           - RGB444 pixel colour (combinational)
//   XPos/YPos      - ball top-left corner
//   XSpeed/YSpeed  - signed pixels per frame
module vga_controller
  import vga_controller_pkg::*;
(
  input  logic        CLK,
  input  logic        ARST_L,
  input  logic [9:0]  HCOORD,
  input  logic [9:0]  VCOORD,
  output logic        rollover_i,
  output logic [17:0] SREG,
  output logic [11:0] CSEL,
  output logic [9:0]  XPos,
  output logic [9:0]  YPos,
  output logic [5:0]  XSpeed,
  output logic [5:0]  YSpeed
);

  logic        rollover_s;
  logic [17:0] sreg_s;
  logic [5:0]  x_mag_s;
  logic [5:0]  y_mag_s;
  logic [10:0] x_end_s;
  logic [10:0] y_end_s;
  logic [11:0] csel_s;
  axis_state_t x_state_r;
  axis_state_t y_state_r;
  axis_state_t x_next_s;
  axis_state_t y_next_s;

  assign rollover_s = (HCOORD == H_MAX) && (VCOORD == V_MAX);
  assign rollover_i = rollover_s;

  lfsr18 u_lfsr (
    .CLK    (CLK),
    .ARST_L (ARST_L),
    .q      (sreg_s)
  );

  assign SREG = sreg_s;

`ifdef VGA_CTRL_RANDOM_SPEED_EN
  assign x_mag_s = {3'b000, sreg_s[2:0]} + 6'd1;
  assign y_mag_s = {3'b000, sreg_s[5:3]} + 6'd1;
`else
  assign x_mag_s = speed_mag(x_state_r.speed);
  assign y_mag_s = speed_mag(y_state_r.speed);
`endif

  assign x_next_s = axis_bounce(x_state_r, X_LIMIT, x_mag_s);
  assign y_next_s = axis_bounce(y_state_r, Y_LIMIT, y_mag_s);

  // Ball position/speed: advance both axes once per frame tick.
  always_ff @(posedge CLK or posedge ARST_L) begin
    if (ARST_L) begin
      x_state_r <= '{pos: RST_XPOS, speed: RST_XSPEED};
      y_state_r <= '{pos: RST_YPOS, speed: RST_YSPEED};
    end else if (rollover_s) begin
      x_state_r <= x_next_s;
      y_state_r <= y_next_s;
    end else begin
      x_state_r <= x_state_r;
      y_state_r <= y_state_r;
    end
  end

  assign XPos   = x_state_r.pos;
  assign YPos   = y_state_r.pos;
  assign XSpeed = x_state_r.speed;
  assign YSpeed = y_state_r.speed;

  // Ball extent computed at 11 bits so pos+16 never wraps.
  assign x_end_s = {1'b0, x_state_r.pos} + {1'b0, BALL_SIZE};
  assign y_end_s = {1'b0, y_state_r.pos} + {1'b0, BALL_SIZE};

  // Pixel colour: blanking outside the visible area, ball, else background.
  always_comb begin
    csel_s = BG_COLOR;
    if ((HCOORD >= H_VISIBLE) || (VCOORD >= V_VISIBLE)) begin
      csel_s = BLANK_COLOR;
    end else if ((HCOORD >= x_state_r.pos) && ({1'b0, HCOORD} < x_end_s) &&
                 (VCOORD >= y_state_r.pos) && ({1'b0, VCOORD} < y_end_s)) begin
      csel_s = BALL_COLOR;
    end else begin
      csel_s = BG_COLOR;
    end
  end

  assign CSEL = csel_s;

endmodule

// File: tb/tb_vga_controller.sv
// tb_vga_controller
// Randomised scoreboard bench for vga_controller. Stimulus pushes expected
// output values (from a frame-level arithmetic model) into a queue; a monitor
// on the falling edge pops and compares against the DUT.
module tb_vga_controller;

  logic        CLK = 1'b0;
  logic        ARST_L;
  logic [9:0]  HCOORD;
  logic [9:0]  VCOORD;
  logic        rollover_i;
  logic [17:0] SREG;
  logic [11:0] CSEL;
  logic [9:0]  XPos;
  logic [9:0]  YPos;
  logic [5:0]  XSpeed;
  logic [5:0]  YSpeed;

  vga_controller dut (
    .CLK        (CLK),
    .ARST_L     (ARST_L),
    .HCOORD     (HCOORD),
    .VCOORD     (VCOORD),
    .rollover_i (rollover_i),
    .SREG       (SREG),
    .CSEL       (CSEL),
    .XPos       (XPos),
    .YPos       (YPos),
    .XSpeed     (XSpeed),
    .YSpeed     (YSpeed)
  );

  always #5 CLK = ~CLK;

  // Scoreboard entry: which output, whether it is a fixed directed value, expected value.
  typedef struct packed {
    logic [2:0]  field;
    logic        directed;
    logic [17:0] exp;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state (plain integers).
  int          m_x, m_y, m_vx, m_vy;
  logic [17:0] m_sreg;
  bit          m_rst;

  function automatic string fname(input logic [2:0] f);
    case (f)
      3'd0: return "rollover_i";
      3'd1: return "SREG";
      3'd2: return "CSEL";
      3'd3: return "XPos";
      3'd4: return "YPos";
      3'd5: return "XSpeed";
      3'd6: return "YSpeed";
      default: return "unknown";
    endcase
  endfunction

  function automatic logic [17:0] actual(input logic [2:0] f);
    case (f)
      3'd0: return {17'd0, rollover_i};
      3'd1: return SREG;
      3'd2: return {6'd0, CSEL};
      3'd3: return {8'd0, XPos};
      3'd4: return {8'd0, YPos};
      3'd5: return {12'd0, XSpeed};
      3'd6: return {12'd0, YSpeed};
      default: return 18'h3FFFF;
    endcase
  endfunction

  task automatic compare(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: check every pending expectation while outputs are stable.
  always @(negedge CLK) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      compare(mon_e.directed ? {"directed ", fname(mon_e.field)} : fname(mon_e.field),
              actual(mon_e.field), mon_e.exp);
    end
  end

  task automatic push(input logic [2:0] f, input logic d, input logic [17:0] v);
    exp_t e;
    e.field = f;
    e.directed = d;
    e.exp = v;
    sb_q.push_back(e);
  endtask

  function automatic logic [17:0] lfsr_next(input logic [17:0] s);
    if (s == 18'd0) return 18'd1;
    return ((s << 1) & 18'h3FFFF) | (((s >> 17) ^ (s >> 10)) & 18'd1);
  endfunction

  function automatic logic [11:0] exp_csel(input int h, input int v);
    if (h >= 640 || v >= 480) return 12'h000;
    if (h >= m_x && h < m_x + 16 && v >= m_y && v < m_y + 16) return 12'hFFF;
    return 12'h008;
  endfunction

  task automatic model_reset();
    m_x = 312; m_y = 232; m_vx = 2; m_vy = 1;
    m_sreg = 18'd1;
  endtask

  // One frame of motion along one axis; rmag>0 overrides the bounce magnitude.
  task automatic bounce(inout int p, inout int v, input int lim, input int rmag);
    int nx, mag;
    nx  = p + v;
    mag = (rmag > 0) ? rmag : ((v < 0) ? -v : v);
    if (nx <= 0) begin
      p = 0; v = mag;
    end else if (nx >= lim) begin
      p = lim; v = -mag;
    end else begin
      p = nx;
    end
  endtask

  // Push the model's view of all outputs for the currently driven inputs.
  task automatic push_model();
    int h, v;
    h = int'(HCOORD);
    v = int'(VCOORD);
    push(3'd0, 1'b0, (h == 800 && v == 525) ? 18'd1 : 18'd0);
    push(3'd1, 1'b0, m_sreg);
    push(3'd2, 1'b0, {6'd0, exp_csel(h, v)});
    push(3'd3, 1'b0, 18'(m_x));
    push(3'd4, 1'b0, 18'(m_y));
    push(3'd5, 1'b0, {12'd0, 6'(m_vx)});
    push(3'd6, 1'b0, {12'd0, 6'(m_vy)});
  endtask

  task automatic drive(input int h, input int v);
    HCOORD = 10'(h);
    VCOORD = 10'(v);
    push_model();
  endtask

  // Advance one clock and apply the model's view of that edge.
  task automatic step();
    bit          roll;
    logic [17:0] s_pre;
    int          rmx, rmy;
    roll  = (HCOORD == 10'd800) && (VCOORD == 10'd525);
    s_pre = m_sreg;
    @(posedge CLK);
    if (!m_rst) begin
      if (roll) begin
`ifdef VGA_CTRL_RANDOM_SPEED_EN
        rmx = int'(s_pre[2:0]) + 1;
        rmy = int'(s_pre[5:3]) + 1;
`else
        rmx = 0;
        rmy = 0;
`endif
        bounce(m_x, m_vx, 624, rmx);
        bounce(m_y, m_vy, 464, rmy);
      end
      m_sreg = lfsr_next(m_sreg);
    end
    #1;
  endtask

  task automatic rand_drive();
    int h, v;
    if ($urandom_range(0, 2) == 0) begin
      h = m_x + int'($urandom_range(0, 19)) - 2;
      v = m_y + int'($urandom_range(0, 19)) - 2;
    end else begin
      h = int'($urandom_range(0, 800));
      v = int'($urandom_range(0, 525));
    end
    if (h < 0) h = 0;
    if (h > 800) h = 800;
    if (v < 0) v = 0;
    if (v > 525) v = 525;
    if (h == 800 && v == 525) v = 524;
    drive(h, v);
  endtask

  // Frame: two random pixels, then the rollover pixel; ends after driving one
  // post-rollover pixel so the caller can add directed checks for the new state.
  task automatic run_frame();
    step(); rand_drive();
    step(); rand_drive();
    step(); drive(800, 525);
    step(); rand_drive();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARST_L = 1'b1;
    HCOORD = 10'd0;
    VCOORD = 10'd0;
    m_rst  = 1'b1;
    model_reset();

    // Reset state and colour decode while held in reset.
    step(); drive(0, 0);
    push(3'd3, 1'b1, 18'd312);
    push(3'd4, 1'b1, 18'd232);
    push(3'd5, 1'b1, 18'd2);
    push(3'd6, 1'b1, 18'd1);
    push(3'd1, 1'b1, 18'h00001);
    push(3'd2, 1'b1, 18'h008);
    step(); drive(320, 240); push(3'd2, 1'b1, 18'hFFF);
    step(); drive(700, 100); push(3'd2, 1'b1, 18'h000);
    step(); drive(800, 525); push(3'd0, 1'b1, 18'd1);
    step(); drive(800, 524); push(3'd0, 1'b1, 18'd0);
    push(3'd3, 1'b1, 18'd312);

    // Release; LFSR after three clocks.
    step();
    ARST_L = 1'b0;
    m_rst  = 1'b0;
    drive(5, 5);
    step(); drive(5, 6);
    step(); drive(5, 7);
    step(); drive(10, 10); push(3'd1, 1'b1, 18'h00008);

    // First frame.
    step(); drive(800, 525);
    step(); drive(800, 524);
    push(3'd3, 1'b1, 18'd314);
    push(3'd4, 1'b1, 18'd233);

    // Long random run covering all four walls.
    for (int f = 2; f <= 720; f++) begin
      run_frame();
`ifndef VGA_CTRL_RANDOM_SPEED_EN
      if (f == 156) begin
        push(3'd3, 1'b1, 18'd624);
        push(3'd5, 1'b1, 18'h3E);
      end
      if (f == 157) push(3'd3, 1'b1, 18'd622);
      if (f == 232) begin
        push(3'd4, 1'b1, 18'd464);
        push(3'd6, 1'b1, 18'h3F);
      end
`endif
    end

    // Reset asserted with an update pending: takes effect without an edge.
    step();
    ARST_L = 1'b1;
    m_rst  = 1'b1;
    model_reset();
    drive(800, 525);
    push(3'd3, 1'b1, 18'd312);
    push(3'd4, 1'b1, 18'd232);
    step(); drive(800, 525);
    push(3'd3, 1'b1, 18'd312);
    step();
    ARST_L = 1'b0;
    m_rst  = 1'b0;
    drive(0, 0);
    step(); drive(1, 1); push(3'd3, 1'b1, 18'd312);
    step(); drive(800, 525);
    step(); drive(0, 0);
    push(3'd3, 1'b1, 18'd314);
    push(3'd4, 1'b1, 18'd233);

    for (int f = 0; f < 40; f++) begin
      run_frame();
    end

    @(negedge CLK);
    @(negedge CLK);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
